// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// The SPI_REG_AUTOINC_EN build macro is consumed by spi_reg_ctrl, not here.
package spi_reg_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned CMD_WR_BIT = 7;

    localparam logic [BYTE_W-1:0] DEFAULT_ID_BYTE = 8'hD5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    // Split a command byte into direction and start address
    function automatic cmd_t decode_cmd(input logic [BYTE_W-1:0] b);
        cmd_t c;
        c.wr   = b[CMD_WR_BIT];
        c.addr = b[ADDR_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select, with registered
// one-cycle start (falling) and end (rising) pulses.
module spi_cs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_raw_n,
    output logic cs_n,
    output logic cs_start,
    output logic cs_end
);

    logic meta_n;

    // Edge pulses are aligned with the cycle in which cs_n changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_n   <= 1'b1;
            cs_n     <= 1'b1;
            cs_start <= 1'b0;
            cs_end   <= 1'b0;
        end else begin
            meta_n   <= cs_raw_n;
            cs_n     <= meta_n;
            cs_start <= cs_n & ~meta_n;
            cs_end   <= ~cs_n & meta_n;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave register-file controller: command byte selects read/write and
// start address. Define SPI_REG_AUTOINC_EN to auto-increment the address.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned       NUM_REGS = 16,
    parameter logic [BYTE_W-1:0] ID_BYTE  = DEFAULT_ID_BYTE
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_RX_DV,
    input  logic [BYTE_W-1:0]        i_RX_Byte,
    output logic                     o_TX_DV,
    output logic [BYTE_W-1:0]        o_TX_Byte,
    input  logic                     i_SPI_CS_n,
    output logic [NUM_REGS*8-1:0]    o_Regs,
    output logic                     o_Wr_Strobe,
    output logic [ADDR_W-1:0]        o_Wr_Addr,
    output logic [BYTE_W-1:0]        o_Wr_Data,
    output logic                     o_Busy
);

    logic cs_n;
    logic cs_start;
    logic cs_end;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     step_addr;
    cmd_t                  cmd;
    logic                  tx_dv_d;
    logic [BYTE_W-1:0]     tx_byte_d;
    logic                  wr_strobe_d;
    logic [ADDR_W-1:0]     wr_addr_d;
    logic [BYTE_W-1:0]     wr_data_d;
    logic [NUM_REGS*8-1:0] regs_q;

    spi_cs_sync u_cs_sync (
        .clk      (i_Clk),
        .rst_n    (i_Rst_L),
        .cs_raw_n (i_SPI_CS_n),
        .cs_n     (cs_n),
        .cs_start (cs_start),
        .cs_end   (cs_end)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Addresses outside the register file read back as zero
    function automatic logic [BYTE_W-1:0] reg_read(input logic [NUM_REGS*8-1:0] r,
                                                   input logic [ADDR_W-1:0]     a);
        logic [BYTE_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (a == ADDR_W'(k)) begin
                v = r[8*k +: 8];
            end
        end
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return a + ADDR_W'(1);
`else
        return a;
`endif
    endfunction

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = o_TX_Byte;
        wr_strobe_d = 1'b0;
        wr_addr_d   = o_Wr_Addr;
        wr_data_d   = o_Wr_Data;
        cmd         = decode_cmd(i_RX_Byte);
        step_addr   = next_addr(addr_q);

        case (state_q)
            IDLE: begin
                if (cs_start) begin
                    state_d   = CMD;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = ID_BYTE;
                end
            end
            CMD: begin
                if (i_RX_DV) begin
                    addr_d = cmd.addr;
                    if (cmd.wr) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = READ;
                        tx_dv_d   = ~cs_end;
                        tx_byte_d = reg_read(regs_q, cmd.addr);
                    end
                end
            end
            WRITE: begin
                if (i_RX_DV) begin
                    addr_d = step_addr;
                    if (in_range(addr_q)) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = i_RX_Byte;
                    end
                end
            end
            READ: begin
                if (i_RX_DV) begin
                    addr_d    = step_addr;
                    tx_dv_d   = ~cs_end;
                    tx_byte_d = reg_read(regs_q, step_addr);
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving with the end edge is still consumed above
        if (cs_end) begin
            state_d = IDLE;
        end
        // Guarantees TX loads are never back to back
        if (o_TX_DV) begin
            tx_dv_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            addr_q      <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Wr_Strobe <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= '0;
            o_Busy      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            o_TX_DV     <= tx_dv_d;
            o_TX_Byte   <= tx_byte_d;
            o_Wr_Strobe <= wr_strobe_d;
            o_Wr_Addr   <= wr_addr_d;
            o_Wr_Data   <= wr_data_d;
            o_Busy      <= ~cs_n;
        end
    end

    // Register file commits in the same cycle the write strobe is presented
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            regs_q <= '0;
        end else if (wr_strobe_d) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_addr_d == ADDR_W'(k)) begin
                    regs_q[8*k +: 8] <= wr_data_d;
                end
            end
        end
    end

    assign o_Regs = regs_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized self-checking bench for spi_reg_ctrl against a transaction-level
// register model; honours SPI_REG_AUTOINC_EN the same way the design does.
module tb_spi_reg_ctrl;

    localparam int unsigned NREGS = 16;
    localparam logic [7:0]  ID    = 8'hD5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rx_dv = 1'b0;
    logic [7:0]           rx_byte = 8'h00;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 cs_n = 1'b1;
    logic [NREGS*8-1:0]   regs;
    logic                 wr_strobe;
    logic [6:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 busy;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.NUM_REGS(NREGS), .ID_BYTE(ID)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_SPI_CS_n  (cs_n),
        .o_Regs      (regs),
        .o_Wr_Strobe (wr_strobe),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference register file, 128 deep so every 7-bit address indexes it
    logic [7:0]  model [128];
    logic [7:0]  tx_q [$];
    logic [14:0] wr_q [$];
    logic        prev_tx = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_dv) begin
                check_eq("tx_dv_gap", 128'(prev_tx), 128'(0));
                tx_q.push_back(tx_byte);
            end
            if (wr_strobe) wr_q.push_back({wr_addr, wr_data});
            prev_tx = tx_dv;
        end else begin
            prev_tx = 1'b0;
        end
    end

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return (32'(a) < NREGS) ? model[a] : 8'h00;
    endfunction

    function automatic logic [6:0] model_step(input logic [6:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return (a == 7'd127) ? 7'd0 : a + 7'd1;
`else
        return a;
`endif
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < int'(NREGS); k++) f[8*k +: 8] = model[k];
        return f;
    endfunction

    task automatic pulse_rx(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    // One CS-framed transaction; coincide puts the last byte on the end edge
    task automatic do_txn(input logic [7:0] b[$], input bit coincide);
        logic [7:0]  exp_tx [$];
        logic [14:0] exp_wr [$];
        logic [7:0]  cmd;
        logic [6:0]  a;
        int          last;
        int          n;

        exp_tx.push_back(ID);
        last = b.size() - 1;
        if (b.size() > 0) begin
            cmd = b[0];
            a   = cmd[6:0];
            if (!cmd[7]) begin
                if (!(coincide && last == 0)) exp_tx.push_back(model_rd(a));
                for (int i = 1; i <= last; i++) begin
                    a = model_step(a);
                    if (!(coincide && i == last)) exp_tx.push_back(model_rd(a));
                end
            end else begin
                for (int i = 1; i <= last; i++) begin
                    if (32'(a) < NREGS) begin
                        exp_wr.push_back({a, b[i]});
                        model[a] = b[i];
                    end
                    a = model_step(a);
                end
            end
        end

        tx_q.delete(); wr_q.delete();
        cs_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        check_eq("busy_on", 128'(busy), 128'(1));
        for (int i = 0; i <= last; i++) begin
            if (coincide && i == last) begin
                cs_n = 1'b1;
                @(posedge clk); @(posedge clk); #1;
                pulse_rx(b[i]);
            end else begin
                pulse_rx(b[i]);
                repeat (6) @(posedge clk); #1;
            end
        end
        cs_n = 1'b1;
        repeat (5) @(posedge clk); #1;

        check_eq("busy_off", 128'(busy), 128'(0));
        check_eq("tx_count", 128'(tx_q.size()), 128'(exp_tx.size()));
        n = (tx_q.size() < exp_tx.size()) ? tx_q.size() : exp_tx.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("tx_byte[%0d]", i), 128'(tx_q[i]), 128'(exp_tx[i]));
        check_eq("wr_count", 128'(wr_q.size()), 128'(exp_wr.size()));
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("wr_addr_data[%0d]", i), 128'(wr_q[i]), 128'(exp_wr[i]));
        check_eq("regs", 128'(regs), model_flat());
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tx_dv"},     128'(tx_dv),     128'(0));
        check_eq({tag, "_tx_byte"},   128'(tx_byte),   128'(0));
        check_eq({tag, "_wr_strobe"}, 128'(wr_strobe), 128'(0));
        check_eq({tag, "_wr_addr"},   128'(wr_addr),   128'(0));
        check_eq({tag, "_wr_data"},   128'(wr_data),   128'(0));
        check_eq({tag, "_busy"},      128'(busy),      128'(0));
        check_eq({tag, "_regs"},      128'(regs),      128'(0));
    endtask

    initial begin
        logic [7:0] q [$];
        logic [6:0] a;
        int         nd;
        bit         co;

        for (int k = 0; k < 128; k++) model[k] = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // CS framing with no bytes: only the ID byte is loaded
        q = {}; do_txn(q, 1'b0);
        // Single write to reg 3
        q = {8'h83, 8'h5A}; do_txn(q, 1'b0);
        // Preload regs 2..5, then a multi-byte read from 2
        q = {8'h82, 8'h11}; do_txn(q, 1'b0);
        q = {8'h83, 8'h22}; do_txn(q, 1'b0);
        q = {8'h84, 8'h33}; do_txn(q, 1'b0);
        q = {8'h85, 8'h44}; do_txn(q, 1'b0);
        q = {8'h02, 8'h00, 8'h00, 8'h00}; do_txn(q, 1'b0);
        // Out-of-range write then read at 127 (wraps to 0 when incrementing)
        q = {8'hFF, 8'hA5}; do_txn(q, 1'b0);
        q = {8'h7F, 8'h00}; do_txn(q, 1'b0);
        // Data byte coincident with the end edge is still committed
        q = {8'h87, 8'h3C, 8'hC3}; do_txn(q, 1'b1);
        q = {8'h07, 8'h00, 8'h00}; do_txn(q, 1'b1);

        // Bytes with CS high are ignored
        tx_q.delete(); wr_q.delete();
        pulse_rx(8'h85); repeat (3) @(posedge clk); #1;
        pulse_rx(8'h77); repeat (3) @(posedge clk); #1;
        check_eq("idle_tx_count", 128'(tx_q.size()), 128'(0));
        check_eq("idle_wr_count", 128'(wr_q.size()), 128'(0));
        check_eq("idle_regs", 128'(regs), model_flat());

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(0, 127));
            else if ($urandom_range(0, 5) == 0) a = 7'($urandom_range(124, 127));
            else a = 7'($urandom_range(0, NREGS - 1));
            nd = $urandom_range(0, 4);
            co = (nd > 0) && ($urandom_range(0, 4) == 0);
            q = {};
            q.push_back({1'($urandom_range(0, 1)), a});
            for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
            do_txn(q, co);
        end

        // Reset in the middle of a read transaction
        cs_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        pulse_rx(8'h03);
        repeat (6) @(posedge clk); #1;
        pulse_rx(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int k = 0; k < 128; k++) model[k] = 8'h00;
        cs_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        tx_q.delete(); wr_q.delete();
        repeat (5) @(posedge clk); #1;
        check_eq("post_reset_tx_count", 128'(tx_q.size()), 128'(0));
        q = {8'h03, 8'h00}; do_txn(q, 1'b0);
        q = {8'h81, 8'h9E}; do_txn(q, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
